// File: rtl/kernel_filter.sv
// ---------------------------------------------------------------------------
// kernel_filter
//
// Programmable 3x3 convolution stage placed directly after the 3x3 kernel
// row-buffer stage. Each pixel token carries a full 3x3 kernel. The stage
// multiplies it by nine signed coefficients, sums the products, rounds,
// arithmetic-shifts and clamps the sum, and emits one filtered pixel.
// Non-pixel tokens (header, row/frame start/end) pass through unchanged with
// the same 3-clock latency, and datao holds its last value while they pass.
//
// Coefficients, shift and enable live in shadow registers that load only on
// a frame-start token, so every pixel of a frame uses one consistent setting.
// shift and enable travel down the pipeline with each pixel. A frame start
// that arrives while earlier pixels are still in flight therefore cannot
// change how those pixels are finished.
//
// Optional feature (compile-time macro KERNEL_FILTER_STATS_EN):
//   defined   : sat_count reports how many pixels were clamped in the
//               previous frame (16-bit, saturating).
//   undefined : sat_count is tied to 0 and no counter is built.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   filter enable (shadowed at frame start; 0 = bypass)
//   coeffs       in   9 signed coefficients, k=r*3+c, r=0 is the oldest row
//   shift        in   right-shift amount 0..15 (shadowed at frame start)
//   dvi          in   token valid
//   dtypei       in   token type
//   meta_datai   in   header/meta word
//   kernel_datai in   9 unsigned pixels, centre at k=4
//   dvo          out  token valid (registered)
//   dtypeo       out  token type (registered)
//   meta_datao   out  meta word (registered)
//   datao        out  filtered pixel, valid when dvo is high on a pixel type
//   sat_count    out  clamped-pixel count of the previous frame
// ---------------------------------------------------------------------------
module kernel_filter #(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COEFF_WIDTH = 8,
    parameter int unsigned DTYPE_WIDTH = 8,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = DTYPE_WIDTH'(8'h01),
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = DTYPE_WIDTH'(8'h02),
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = DTYPE_WIDTH'(8'hE0)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [9*COEFF_WIDTH-1:0] coeffs,
    input  logic [3:0]               shift,
    input  logic                     dvi,
    input  logic [DTYPE_WIDTH-1:0]   dtypei,
    input  logic [DATA_WIDTH-1:0]    meta_datai,
    input  logic [9*PIXEL_WIDTH-1:0] kernel_datai,
    output logic                     dvo,
    output logic [DTYPE_WIDTH-1:0]   dtypeo,
    output logic [DATA_WIDTH-1:0]    meta_datao,
    output logic [PIXEL_WIDTH-1:0]   datao,
    output logic [15:0]              sat_count
);

    // A product is an 11-bit zero-extended pixel times an 8-bit signed
    // coefficient. A row adds three products, and the accumulator adds
    // three rows plus headroom for the rounding bias.
    localparam int unsigned PROD_W = PIXEL_WIDTH + COEFF_WIDTH + 1;
    localparam int unsigned ROW_W  = PROD_W + 2;
    localparam int unsigned ACC_W  = PIXEL_WIDTH + COEFF_WIDTH + 5;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** PIXEL_WIDTH) - 1);

    // ---------------- shadow registers ----------------
    logic signed [COEFF_WIDTH-1:0] sh_coeff [9];
    logic [3:0]                    sh_shift;
    logic                          sh_en;
    logic                          fs_in;

    assign fs_in = dvi && (dtypei == DTYPE_FRAME_START);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < 9; k++) begin
                sh_coeff[k] <= '0;
            end
            sh_coeff[4] <= COEFF_WIDTH'(1);
            sh_shift    <= '0;
            sh_en       <= 1'b0;
        end else if (fs_in) begin
            for (int unsigned k = 0; k < 9; k++) begin
                sh_coeff[k] <= coeffs[k*COEFF_WIDTH +: COEFF_WIDTH];
            end
            sh_shift <= shift;
            sh_en    <= enable;
        end
    end

    // ---------------- pipeline registers ----------------
    logic                          s1_dv;
    logic [DTYPE_WIDTH-1:0]        s1_dtype;
    logic [DATA_WIDTH-1:0]         s1_meta;
    logic signed [PROD_W-1:0]      s1_prod [9];
    logic [PIXEL_WIDTH-1:0]        s1_centre;
    logic [3:0]                    s1_shift;
    logic                          s1_en;

    logic                          s2_dv;
    logic [DTYPE_WIDTH-1:0]        s2_dtype;
    logic [DATA_WIDTH-1:0]         s2_meta;
    logic signed [ROW_W-1:0]       s2_row [3];
    logic [PIXEL_WIDTH-1:0]        s2_centre;
    logic [3:0]                    s2_shift;
    logic                          s2_en;

    // ---------------- S3 combinational arithmetic ----------------
    logic signed [ACC_W-1:0]       acc_sum;
    logic signed [ACC_W-1:0]       acc_bias;
    logic signed [ACC_W-1:0]       acc_shr;
    logic [PIXEL_WIDTH-1:0]        flt_pix;
    logic                          flt_clamped;
    logic                          s3_pixel;

    assign s3_pixel = s2_dv && (|(s2_dtype & DTYPE_PIXEL_MASK));

    always_comb begin
        acc_sum  = ACC_W'(s2_row[0]) + ACC_W'(s2_row[1]) + ACC_W'(s2_row[2]);
        acc_bias = '0;
        if (s2_shift != 4'd0) begin
            acc_bias[s2_shift - 4'd1] = 1'b1;
        end
        acc_shr     = (acc_sum + acc_bias) >>> s2_shift;
        flt_pix     = acc_shr[PIXEL_WIDTH-1:0];
        flt_clamped = 1'b0;
        if (acc_shr[ACC_W-1]) begin
            flt_pix     = '0;
            flt_clamped = 1'b1;
        end else if (acc_shr > PIX_MAX) begin
            flt_pix     = '1;
            flt_clamped = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_dv      <= 1'b0;
            s1_dtype   <= '0;
            s1_meta    <= '0;
            s1_centre  <= '0;
            s1_shift   <= '0;
            s1_en      <= 1'b0;
            for (int unsigned k = 0; k < 9; k++) begin
                s1_prod[k] <= '0;
            end
            s2_dv      <= 1'b0;
            s2_dtype   <= '0;
            s2_meta    <= '0;
            s2_centre  <= '0;
            s2_shift   <= '0;
            s2_en      <= 1'b0;
            for (int unsigned r = 0; r < 3; r++) begin
                s2_row[r] <= '0;
            end
            dvo        <= 1'b0;
            dtypeo     <= '0;
            meta_datao <= '0;
            datao      <= '0;
        end else begin
            // S1: products. The shadow values read here are the ones in
            // force before this edge, so a pixel after a frame start uses
            // the newly loaded set.
            s1_dv     <= dvi;
            s1_dtype  <= dtypei;
            s1_meta   <= meta_datai;
            s1_centre <= kernel_datai[4*PIXEL_WIDTH +: PIXEL_WIDTH];
            s1_shift  <= sh_shift;
            s1_en     <= sh_en;
            for (int unsigned k = 0; k < 9; k++) begin
                s1_prod[k] <= PROD_W'($signed({1'b0, kernel_datai[k*PIXEL_WIDTH +: PIXEL_WIDTH]}))
                            * PROD_W'(sh_coeff[k]);
            end

            // S2: row sums
            s2_dv     <= s1_dv;
            s2_dtype  <= s1_dtype;
            s2_meta   <= s1_meta;
            s2_centre <= s1_centre;
            s2_shift  <= s1_shift;
            s2_en     <= s1_en;
            for (int unsigned r = 0; r < 3; r++) begin
                s2_row[r] <= ROW_W'(s1_prod[3*r]) + ROW_W'(s1_prod[3*r+1])
                           + ROW_W'(s1_prod[3*r+2]);
            end

            // S3: round/shift/clamp into the output registers
            dvo        <= s2_dv;
            dtypeo     <= s2_dtype;
            meta_datao <= s2_meta;
            if (s3_pixel) begin
                datao <= s2_en ? flt_pix : s2_centre;
            end
        end
    end

`ifdef KERNEL_FILTER_STATS_EN
    // The counter follows tokens as they leave S3, so its frame boundaries
    // line up with the tokens that appear on the outputs.
    logic [15:0] sat_cnt;
    logic        s3_fs;
    logic        s3_fe;

    assign s3_fs = s2_dv && (s2_dtype == DTYPE_FRAME_START);
    assign s3_fe = s2_dv && (s2_dtype == DTYPE_FRAME_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt   <= '0;
            sat_count <= '0;
        end else if (s3_fs) begin
            sat_cnt <= '0;
        end else if (s3_fe) begin
            sat_count <= sat_cnt;
            sat_cnt   <= '0;
        end else if (s3_pixel && s2_en && flt_clamped && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_kernel_filter.sv
// ---------------------------------------------------------------------------
// tb_kernel_filter
//
// Scoreboard bench for kernel_filter. Each valid token driven pushes its
// expected output (due cycle, type, meta, pixel and sat_count) onto a
// queue. A monitor pops the entry on the cycle it falls due and compares it.
// On cycles with nothing due, the monitor requires dvo low.
// ---------------------------------------------------------------------------
module tb_kernel_filter;

    localparam int PW = 10;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int TW = 8;

    localparam logic [7:0] T_FS   = 8'h01;
    localparam logic [7:0] T_FE   = 8'h02;
    localparam logic [7:0] T_RS   = 8'h04;
    localparam logic [7:0] T_RE   = 8'h08;
    localparam logic [7:0] T_HDR  = 8'h10;
    localparam logic [7:0] T_PIX  = 8'h20;
    localparam logic [7:0] T_PIX2 = 8'h40;
    localparam logic [7:0] PIXMSK = 8'hE0;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [71:0]   coeffs;
    logic [3:0]    shift;
    logic          dvi;
    logic [7:0]    dtypei;
    logic [15:0]   meta_datai;
    logic [89:0]   kernel_datai;
    logic          dvo;
    logic [7:0]    dtypeo;
    logic [15:0]   meta_datao;
    logic [9:0]    datao;
    logic [15:0]   sat_count;

    kernel_filter #(
        .PIXEL_WIDTH       (PW),
        .DATA_WIDTH        (DW),
        .COEFF_WIDTH       (CW),
        .DTYPE_WIDTH       (TW),
        .DTYPE_FRAME_START (T_FS),
        .DTYPE_FRAME_END   (T_FE),
        .DTYPE_PIXEL_MASK  (PIXMSK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .coeffs       (coeffs),
        .shift        (shift),
        .dvi          (dvi),
        .dtypei       (dtypei),
        .meta_datai   (meta_datai),
        .kernel_datai (kernel_datai),
        .dvo          (dvo),
        .dtypeo       (dtypeo),
        .meta_datao   (meta_datao),
        .datao        (datao),
        .sat_count    (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned due;
        logic [7:0]  dtype;
        logic [15:0] meta;
        logic [9:0]  data;
        logic [15:0] sat;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    bit          mon_on = 1'b0;

    // reference model state
    int          m_coef[9];
    int          m_shift;
    bit          m_en;
    logic [9:0]  m_last;
    int          m_cnt;
    logic [15:0] m_sat;

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_coef[i] = 0;
        m_coef[4] = 1;
        m_shift   = 0;
        m_en      = 1'b0;
        m_last    = '0;
        m_cnt     = 0;
        m_sat     = '0;
    endtask

    function automatic int raw_filter(input logic [89:0] kern);
        int sum = 0;
        for (int i = 0; i < 9; i++) begin
            sum += int'(kern[i*10 +: 10]) * m_coef[i];
        end
        if (m_shift > 0) sum += 1 << (m_shift - 1);
        return sum >>> m_shift;
    endfunction

    task automatic send(input bit dv, input logic [7:0] dt, input logic [15:0] md,
                        input logic [89:0] kern);
        exp_t e;
        int   r;
        @(negedge clk);
        dvi          = dv;
        dtypei       = dt;
        meta_datai   = md;
        kernel_datai = kern;
        if (dv && ((dt & PIXMSK) != 8'h00)) begin
            if (m_en) begin
                r = raw_filter(kern);
                if (r < 0) begin
                    m_last = 10'd0;
                    if (m_cnt < 65535) m_cnt++;
                end else if (r > 1023) begin
                    m_last = 10'd1023;
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_last = 10'(r);
                end
            end else begin
                m_last = kern[40 +: 10];
            end
        end
        if (dv && dt == T_FS) begin
            m_cnt = 0;
            for (int i = 0; i < 9; i++) m_coef[i] = int'($signed(coeffs[i*8 +: 8]));
            m_shift = int'(shift);
            m_en    = enable;
        end
        if (dv && dt == T_FE) begin
            m_sat = 16'(m_cnt);
            m_cnt = 0;
        end
        if (dv) begin
            e.due   = cyc + 3;
            e.dtype = dt;
            e.meta  = md;
            e.data  = m_last;
`ifdef KERNEL_FILTER_STATS_EN
            e.sat   = m_sat;
`else
            e.sat   = 16'h0000;
`endif
            sbq.push_back(e);
        end
    endtask

    function automatic logic [89:0] krand();
        logic [89:0] k;
        for (int i = 0; i < 9; i++) k[i*10 +: 10] = 10'($urandom_range(0, 1023));
        return k;
    endfunction

    function automatic logic [89:0] kfill(input int c, input int nb);
        logic [89:0] k;
        for (int i = 0; i < 9; i++) k[i*10 +: 10] = 10'((i == 4) ? c : nb);
        return k;
    endfunction

    function automatic logic [89:0] kcentre(input int c);
        logic [89:0] k;
        k = krand();
        k[40 +: 10] = 10'(c);
        return k;
    endfunction

    task automatic set_cf(input int c4, input int oth);
        for (int i = 0; i < 9; i++) coeffs[i*8 +: 8] = 8'((i == 4) ? c4 : oth);
    endtask

    task automatic idle(input bit fake_fs);
        send(1'b0, fake_fs ? T_FS : 8'($urandom), 16'($urandom), krand());
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dvo"},  32'(dvo), 32'h0);
        chk({tag, "_dtype"}, 32'(dtypeo), 32'h0);
        chk({tag, "_meta"}, 32'(meta_datao), 32'h0);
        chk({tag, "_data"}, 32'(datao), 32'h0);
        chk({tag, "_sat"},  32'(sat_count), 32'h0);
    endtask

    // monitor: compare the entry that falls due on this cycle
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (mon_on && !reset) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("dvo",   32'(dvo), 32'h1);
                chk("dtype", 32'(dtypeo), 32'(e.dtype));
                chk("meta",  32'(meta_datao), 32'(e.meta));
                chk("datao", 32'(datao), 32'(e.data));
                chk("sat",   32'(sat_count), 32'(e.sat));
            end else begin
                chk("dvo_bubble", 32'(dvo), 32'h0);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        coeffs       = '0;
        shift        = '0;
        dvi          = 1'b0;
        dtypei       = '0;
        meta_datai   = '0;
        kernel_datai = '0;
        model_reset();
        #2;
        chk_zero_outputs("rst");
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_on = 1'b1;

        // before any frame start the reset shadow bypasses the centre pixel
        send(1'b1, T_PIX, 16'h0F0F, kcentre(777));

        // identity: k4=16, shift 4
        set_cf(16, 0); shift = 4'd4; enable = 1'b1;
        send(1'b1, T_FS,  16'h1111, krand());
        send(1'b1, T_HDR, 16'hABCD, krand());
        send(1'b1, T_RS,  16'h2222, krand());
        send(1'b1, T_PIX, 16'h0001, kcentre(517));
        send(1'b1, T_PIX2, 16'h0002, krand());
        idle(1'b0);
        send(1'b1, T_PIX, 16'h0003, krand());
        send(1'b1, T_RE,  16'h3333, krand());
        send(1'b1, T_FE,  16'h4444, krand());

        // box: all ones, shift 3
        set_cf(1, 1); shift = 4'd3;
        send(1'b1, T_FS,  16'h0100, krand());
        send(1'b1, T_PIX, 16'h0101, kfill(100, 100));
        send(1'b1, T_PIX, 16'h0102, kfill(1023, 1023));
        for (int i = 0; i < 3; i++) send(1'b1, T_PIX, 16'(16'h0110 + i), krand());
        send(1'b1, T_FE,  16'h01FF, krand());

        // laplacian: k4=8, others -1, shift 0
        set_cf(8, -1); shift = 4'd0;
        send(1'b1, T_FS,  16'h0200, krand());
        send(1'b1, T_PIX, 16'h0201, kfill(0, 1023));
        send(1'b1, T_PIX, 16'h0202, kfill(1023, 0));
        send(1'b1, T_PIX, 16'h0203, kfill(50, 50));
        send(1'b1, T_FE,  16'h02FF, krand());

        // mid-frame coefficient change waits for the next frame start
        set_cf(16, 0); shift = 4'd4;
        send(1'b1, T_FS,  16'h0300, krand());
        send(1'b1, T_PIX, 16'h0301, krand());
        set_cf(1, 1); shift = 4'd3; enable = 1'b0;
        send(1'b1, T_PIX, 16'h0302, kfill(100, 100));
        send(1'b1, T_PIX, 16'h0303, krand());
        enable = 1'b1;
        send(1'b1, T_FS,  16'h0310, krand());
        send(1'b1, T_PIX, 16'h0311, kfill(100, 100));
        send(1'b1, T_FE,  16'h03FF, krand());

        // bypass: enable=0 with nonzero coeffs
        enable = 1'b0; set_cf(8, -1);
        send(1'b1, T_FS,  16'h0400, krand());
        send(1'b1, T_HDR, 16'hBEEF, krand());
        for (int i = 0; i < 3; i++) send(1'b1, T_PIX, 16'(16'h0401 + i), krand());
        send(1'b1, T_FE,  16'h04FF, krand());

        // back-to-back frame starts: the last one wins
        enable = 1'b1; set_cf(16, 0); shift = 4'd4;
        send(1'b1, T_FS,  16'h0500, krand());
        set_cf(8, -1); shift = 4'd0;
        send(1'b1, T_FS,  16'h0501, krand());
        send(1'b1, T_PIX, 16'h0502, kfill(300, 200));
        send(1'b1, T_PIX, 16'h0503, krand());
        // an invalid frame-start type must not reload the shadow
        set_cf(1, 1); shift = 4'd3;
        idle(1'b1);
        send(1'b1, T_PIX, 16'h0504, kfill(300, 200));
        send(1'b1, T_FE,  16'h05FF, krand());

        // random coefficients, maximum shift then random shifts
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 9; i++) coeffs[i*8 +: 8] = 8'($urandom);
            shift = (f == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            send(1'b1, T_FS, 16'(16'h0600 + f), krand());
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1'b0);
                send(1'b1, (i[0] ? T_PIX2 : T_PIX), 16'($urandom), krand());
            end
            send(1'b1, T_FE, 16'(16'h06F0 + f), krand());
        end

        // reset mid-row with tokens in flight
        set_cf(8, -1); shift = 4'd0; enable = 1'b1;
        send(1'b1, T_FS,  16'h0700, krand());
        send(1'b1, T_RS,  16'h0701, krand());
        for (int i = 0; i < 3; i++) send(1'b1, T_PIX, 16'(16'h0702 + i), kfill(500, 10));
        @(posedge clk);
        #2;
        dvi   = 1'b0;
        reset = 1'b1;
        sbq.delete();
        #1;
        chk_zero_outputs("midrst");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // fresh laplacian frame after the reset
        send(1'b1, T_FS,  16'h0800, krand());
        send(1'b1, T_PIX, 16'h0801, kfill(0, 1023));
        send(1'b1, T_PIX, 16'h0802, kfill(1023, 0));
        send(1'b1, T_PIX, 16'h0803, kfill(50, 50));
        send(1'b1, T_PIX, 16'h0804, krand());
        send(1'b1, T_FE,  16'h08FF, krand());

        repeat (6) idle(1'b0);
        chk("sb_drain", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
